// File: rtl/conv_pkg.sv
// Shared constants and types for the buffer / convolve / serializer blocks.
// No logic: parameters and the serializer state encoding only.
// Not applicable: no handshake lives here.
package conv_pkg;

    localparam int ELEM_W   = 8;
    localparam int N_ELEM   = 9;
    localparam int IDX_W    = 4;
    localparam int MATRIX_W = ELEM_W * N_ELEM;

    // Index of the final element of a frame, sized to the index counter.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/conv_result_serializer.sv
// Streams a 72-bit convolve result out as nine bytes, element 0 first.
// Latency: first byte valid one cycle after conv_valid; one byte per accepted handshake.
// Backpressure: tx_ready low holds byte/index; conv_valid arriving mid-frame is dropped and flagged sticky in overrun.
module conv_result_serializer
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ena,
    input  logic [MATRIX_W-1:0] conv_in,
    input  logic                conv_valid,
    input  logic                tx_ready,
    output logic [ELEM_W-1:0]   byte_out,
    output logic                byte_valid,
    output logic [IDX_W-1:0]    byte_idx,
    output logic                frame_last,
    output logic                busy,
    output logic                overrun
);

    ser_state_t          state_q, state_d;
    logic [MATRIX_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                frame_last_q, frame_last_d;
    logic                overrun_q, overrun_d;

    logic                xfer;
    logic                last_xfer;

    // A byte only moves when the element is presented, taken and the block is enabled.
    assign xfer      = (state_q == SEND) && tx_ready && ena;
    assign last_xfer = xfer && (idx_q == LAST_IDX);

    // Next-state: capture in IDLE, shift per transfer, and reload without a bubble on the last byte.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        overrun_d    = overrun_q;
        frame_last_d = frame_last_q;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (conv_valid) begin
                        shreg_d = conv_in;
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        if (conv_valid) begin
                            shreg_d = conv_in;
                            idx_d   = '0;
                        end else begin
                            // Shifting out the last element leaves the register empty,
                            // so byte_out idles at zero.
                            shreg_d = shreg_q >> ELEM_W;
                            idx_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            shreg_d = shreg_q >> ELEM_W;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                        // A new word cannot be accepted mid-frame; the current frame runs on.
                        if (conv_valid) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            frame_last_d = (state_d == SEND) && (idx_d == LAST_IDX);
        end
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            idx_q        <= '0;
            frame_last_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            frame_last_q <= frame_last_d;
            overrun_q    <= overrun_d;
        end
    end

    assign byte_out   = shreg_q[ELEM_W-1:0];
    assign byte_valid = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign byte_idx   = idx_q;
    assign frame_last = frame_last_q;
    assign overrun    = overrun_q;

endmodule
